packet_serializer: RTL

PACKET_SERIALIZER -- requirements
Module: packet_serializer

---
 rtl/packet_serializer.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/packet_serializer.sv
// Packet serializer: captures a reward-stage result, arbitrates for the
// channel, then streams header, payload words and an XOR checksum over a
// valid/ready word interface. Abandons the packet if the grant never comes.
module packet_serializer #(
    parameter int WORD_WIDTH    = 16,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reward_done,
    input  logic [2:0]            rPacketType,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    output logic                  tx_req,
    input  logic                  tx_grant,
    output logic [WORD_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  tx_busy,
    output logic                  tx_abort,
    output logic                  tx_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(GRANT_TIMEOUT - 1);

    // Total words per packet type, header and checksum included; 0 = not sent.
    function automatic logic [3:0] pkt_len(input logic [2:0] ptype);
        logic [3:0] len;
        case (ptype)
            3'b000:  len = 4'd6;
            3'b010:  len = 4'd5;
            3'b011:  len = 4'd6;
            3'b100:  len = 4'd4;
            3'b101:  len = 4'd7;
            3'b110:  len = 4'd7;
            default: len = 4'd0;
        endcase
        return len;
    endfunction

    // Word at position idx of a packet of the given type.
    function automatic logic [WORD_WIDTH-1:0] word_at(
        input logic [2:0]            ptype,
        input logic [2:0]            idx,
        input logic [WORD_WIDTH-1:0] src,
        input logic [WORD_WIDTH-1:0] energy,
        input logic [WORD_WIDTH-1:0] qval,
        input logic [WORD_WIDTH-1:0] hops,
        input logic [WORD_WIDTH-1:0] dest,
        input logic [WORD_WIDTH-1:0] ch,
        input logic [WORD_WIDTH-1:0] hops_ch,
        input logic [WORD_WIDTH-1:0] chk
    );
        logic [WORD_WIDTH-1:0] w;
        logic [3:0]            len;
        len = pkt_len(ptype);
        w   = '0;
        if (idx == 3'd0) begin
            w[WORD_WIDTH-1 -: 3] = ptype;
            w[3:0]               = len;
        end else if ({1'b0, idx} == len - 4'd1) begin
            w = chk;
        end else if (idx == 3'd1) begin
            w = src;
        end else begin
            case (ptype)
                3'b000: begin
                    case (idx)
                        3'd2:    w = hops;
                        3'd3:    w = energy;
                        3'd4:    w = qval;
                        default: w = '0;
                    endcase
                end
                3'b010: begin
                    case (idx)
                        3'd2:    w = ch;
                        3'd3:    w = hops_ch;
                        default: w = '0;
                    endcase
                end
                3'b011: begin
                    case (idx)
                        3'd2:    w = dest;
                        3'd3:    w = energy;
                        3'd4:    w = qval;
                        default: w = '0;
                    endcase
                end
                3'b100: begin
                    case (idx)
                        3'd2:    w = dest;
                        default: w = '0;
                    endcase
                end
                3'b101, 3'b110: begin
                    case (idx)
                        3'd2:    w = dest;
                        3'd3:    w = energy;
                        3'd4:    w = qval;
                        3'd5:    w = hops;
                        default: w = '0;
                    endcase
                end
                default: w = '0;
            endcase
        end
        return w;
    endfunction

    // Checksum: XOR of header and every payload word of the packet.
    function automatic logic [WORD_WIDTH-1:0] checksum(
        input logic [2:0]            ptype,
        input logic [WORD_WIDTH-1:0] src,
        input logic [WORD_WIDTH-1:0] energy,
        input logic [WORD_WIDTH-1:0] qval,
        input logic [WORD_WIDTH-1:0] hops,
        input logic [WORD_WIDTH-1:0] dest,
        input logic [WORD_WIDTH-1:0] ch,
        input logic [WORD_WIDTH-1:0] hops_ch
    );
        logic [WORD_WIDTH-1:0] acc;
        logic [3:0]            len;
        len = pkt_len(ptype);
        acc = '0;
        for (int i = 0; i < 7; i++) begin
            if (4'(i) < len - 4'd1) begin
                acc = acc ^ word_at(ptype, 3'(i), src, energy, qval, hops,
                                    dest, ch, hops_ch, '0);
            end
        end
        return acc;
    endfunction

    state_t                state_q;
    logic [2:0]            type_q;
    logic [WORD_WIDTH-1:0] src_q, energy_q, qval_q, hops_q;
    logic [WORD_WIDTH-1:0] dest_q, ch_q, hops_ch_q, chk_q;
    logic [3:0]            len_q;
    logic [2:0]            idx_q;
    logic [15:0]           wait_q;
    logic [WORD_WIDTH-1:0] tx_data_q;
    logic                  tx_req_q, tx_valid_q, tx_last_q;
    logic                  tx_busy_q, tx_abort_q, tx_overrun_q;

    logic [2:0]            idx_nxt_d;
    logic [WORD_WIDTH-1:0] word_nxt_d;
    logic [WORD_WIDTH-1:0] chk_d;
    logic                  accept_d;

    // Next word to present and the checksum of the packet being offered.
    always_comb begin
        idx_nxt_d  = idx_q + 3'd1;
        word_nxt_d = word_at(type_q, idx_nxt_d, src_q, energy_q, qval_q, hops_q,
                             dest_q, ch_q, hops_ch_q, chk_q);
        chk_d      = checksum(rPacketType, rSourceID, rEnergyLeft, rQValue,
                              rSourceHops, rDestinationID, rChosenCH, rHopsFromCH);
        accept_d   = (pkt_len(rPacketType) != 4'd0);
    end

    // Control FSM with captured fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            type_q       <= 3'd0;
            src_q        <= '0;
            energy_q     <= '0;
            qval_q       <= '0;
            hops_q       <= '0;
            dest_q       <= '0;
            ch_q         <= '0;
            hops_ch_q    <= '0;
            chk_q        <= '0;
            len_q        <= 4'd0;
            idx_q        <= 3'd0;
            wait_q       <= 16'd0;
            tx_data_q    <= '0;
            tx_req_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_abort_q   <= 1'b0;
            tx_overrun_q <= 1'b0;
        end else begin
            tx_abort_q   <= 1'b0;
            tx_overrun_q <= reward_done && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (reward_done && accept_d) begin
                        type_q    <= rPacketType;
                        src_q     <= rSourceID;
                        energy_q  <= rEnergyLeft;
                        qval_q    <= rQValue;
                        hops_q    <= rSourceHops;
                        dest_q    <= rDestinationID;
                        ch_q      <= rChosenCH;
                        hops_ch_q <= rHopsFromCH;
                        chk_q     <= chk_d;
                        len_q     <= pkt_len(rPacketType);
                        wait_q    <= 16'd0;
                        state_q   <= ARB;
                        tx_req_q  <= 1'b1;
                        tx_busy_q <= 1'b1;
                    end
                end
                ARB: begin
                    // A grant in the timeout cycle still wins.
                    if (tx_grant) begin
                        state_q    <= SEND;
                        idx_q      <= 3'd0;
                        tx_req_q   <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                        tx_data_q  <= word_at(type_q, 3'd0, src_q, energy_q, qval_q,
                                              hops_q, dest_q, ch_q, hops_ch_q, chk_q);
                    end else if (wait_q == TIMEOUT_LAST) begin
                        state_q    <= IDLE;
                        tx_req_q   <= 1'b0;
                        tx_busy_q  <= 1'b0;
                        tx_abort_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (tx_last_q) begin
                            state_q    <= IDLE;
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            tx_busy_q  <= 1'b0;
                            tx_data_q  <= '0;
                        end else begin
                            idx_q      <= idx_nxt_d;
                            tx_data_q  <= word_nxt_d;
                            tx_last_q  <= ({1'b0, idx_nxt_d} == len_q - 4'd1);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_req_q   <= 1'b0;
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                    tx_busy_q  <= 1'b0;
                    tx_data_q  <= '0;
                end
            endcase
        end
    end

    assign tx_req     = tx_req_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign tx_last    = tx_last_q;
    assign tx_busy    = tx_busy_q;
    assign tx_abort   = tx_abort_q;
    assign tx_overrun = tx_overrun_q;

endmodule
